// File: rtl/bin_onehot_pkg.sv
// Shared constants and pure helpers for the binary/one-hot codec.
package bin_onehot_pkg;

  localparam int BINOH_W = 4;

  function automatic int onehot_width(input int w);
    return 1 << w;
  endfunction

  localparam int BINOH_N = onehot_width(BINOH_W);

  function automatic logic [BINOH_N-1:0] bin2oh(input logic [BINOH_W-1:0] bin);
    return BINOH_N'(1) << bin;
  endfunction

  // OR-reduction decode: a non-one-hot input yields the OR of its set indices.
  function automatic logic [BINOH_W-1:0] oh2bin(input logic [BINOH_N-1:0] oh);
    logic [BINOH_W-1:0] bin;
    bin = '0;
    for (int i = 0; i < BINOH_N; i++) begin
      if (oh[i]) bin = bin | BINOH_W'(i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/onehot_to_bin_enc.sv
// Combinational OR-reduction one-hot to binary encoder; no priority applied.
module onehot_to_bin_enc
  import bin_onehot_pkg::*;
#(
  parameter int W = BINOH_W
) (
  input  logic [(1<<W)-1:0] oh,
  output logic [W-1:0]      bin
);

  localparam int N = onehot_width(W);

  always_comb begin
    bin = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) bin = bin | W'(i);
    end
  end

endmodule

// File: rtl/bin_onehot_codec.sv
// Registered binary<->one-hot codec with round-trip decode of oh_out.
// Macro BINOH_ONEHOT_CHECK_EN enables the oh_err one-hot check; otherwise oh_err is 0.
module bin_onehot_codec
  import bin_onehot_pkg::*;
#(
  parameter int W = BINOH_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [W-1:0]         bin_in,
  input  logic [(1<<W)-1:0]    oh_in,
  output logic                 out_valid,
  output logic [(1<<W)-1:0]    oh_out,
  output logic [W-1:0]         bin_out,
  output logic [W-1:0]         rt_bin_out,
  output logic                 oh_err
);

  localparam int N = onehot_width(W);
  localparam logic [N-1:0] ONE_N = N'(1);

  logic         out_valid_q, out_valid_d;
  logic [N-1:0] oh_out_q,    oh_out_d;
  logic [W-1:0] bin_out_q,   bin_out_d;
  logic         oh_err_q,    oh_err_d;
  logic [W-1:0] dec_bin;
  logic         not_onehot;

  onehot_to_bin_enc #(.W(W)) u_dec_in (
    .oh  (oh_in),
    .bin (dec_bin)
  );

  onehot_to_bin_enc #(.W(W)) u_dec_rt (
    .oh  (oh_out_q),
    .bin (rt_bin_out)
  );

`ifdef BINOH_ONEHOT_CHECK_EN
  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  always_comb begin
    not_onehot = (oh_in == '0) || ((oh_in & (oh_in - ONE_N)) != '0);
  end
`else
  always_comb begin
    not_onehot = 1'b0;
  end
`endif

  always_comb begin
    out_valid_d = in_valid;
    oh_out_d    = oh_out_q;
    bin_out_d   = bin_out_q;
    oh_err_d    = oh_err_q;
    if (in_valid) begin
      oh_out_d  = ONE_N << bin_in;
      bin_out_d = dec_bin;
      oh_err_d  = not_onehot;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      oh_out_q    <= '0;
      bin_out_q   <= '0;
      oh_err_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      oh_out_q    <= oh_out_d;
      bin_out_q   <= bin_out_d;
      oh_err_q    <= oh_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign oh_out    = oh_out_q;
  assign bin_out   = bin_out_q;
  assign oh_err    = oh_err_q;

endmodule

// File: tb/tb_bin_onehot_codec.sv
// Scoreboard-driven bench for bin_onehot_codec (W=4).
module tb_bin_onehot_codec;
  import bin_onehot_pkg::*;

  localparam int W = 4;
  localparam int N = 16;
`ifdef BINOH_ONEHOT_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    logic [N-1:0] oh;
    logic [W-1:0] bin;
    logic         err;
    logic [W-1:0] rt;
  } exp_t;

  logic         clk, rst, in_valid;
  logic [W-1:0] bin_in;
  logic [N-1:0] oh_in;
  logic         out_valid;
  logic [N-1:0] oh_out;
  logic [W-1:0] bin_out, rt_bin_out;
  logic         oh_err;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  exp_t e;

  bin_onehot_codec #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .bin_in     (bin_in),
    .oh_in      (oh_in),
    .out_valid  (out_valid),
    .oh_out     (oh_out),
    .bin_out    (bin_out),
    .rt_bin_out (rt_bin_out),
    .oh_err     (oh_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N-1:0] model_oh(input int idx);
    logic [N-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Drive one cycle at the falling edge, push the expectation, return at posedge+1.
  task automatic drive(input logic v, input logic [W-1:0] b, input logic [N-1:0] o,
                       input logic [W-1:0] eb, input logic ee);
    exp_t x;
    @(negedge clk);
    in_valid = v;
    bin_in   = b;
    oh_in    = o;
    if (v) begin
      x.oh  = model_oh(int'(b));
      x.bin = eb;
      x.err = ERR_EN ? ee : 1'b0;
      x.rt  = b;
      sb.push_back(x);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t pop_exp();
    exp_t x;
    x.oh = '0; x.bin = '0; x.err = 1'b0; x.rt = '0;
    if (sb.size() > 0) x = sb.pop_front();
    return x;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; bin_in = '0; oh_in = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if ({out_valid, oh_out, bin_out, oh_err, rt_bin_out} !== '0) begin
      n_bad++; $display("FAIL reset_init got ov=%b oh=%h bin=%0d err=%b rt=%0d want all 0",
                        out_valid, oh_out, bin_out, oh_err, rt_bin_out);
    end
    @(negedge clk); rst = 1'b0;
    drive(1'b1, 4'd3, 16'h0400, 4'd10, 1'b0);
    e = pop_exp();
    n_cmp++; if (oh_out !== e.oh || bin_out !== e.bin) begin
      n_bad++; $display("FAIL reset_pre got oh=%h bin=%0d want oh=%h bin=%0d", oh_out, bin_out, e.oh, e.bin);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({out_valid, oh_out, bin_out, oh_err, rt_bin_out} !== '0) begin
      n_bad++; $display("FAIL reset_async got ov=%b oh=%h bin=%0d err=%b rt=%0d want all 0",
                        out_valid, oh_out, bin_out, oh_err, rt_bin_out);
    end
    sb.delete();
    in_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    drive(1'b1, 4'd5, 16'h0020, 4'd5, 1'b0);
    e = pop_exp();
    n_cmp++; if (oh_out !== 16'h0020 || out_valid !== 1'b1) begin
      n_bad++; $display("FAIL reset_release got ov=%b oh=%h want ov=1 oh=0020", out_valid, oh_out);
    end
    n_cmp++; if (rt_bin_out !== 4'd5) begin
      n_bad++; $display("FAIL reset_release_rt got %0d want 5", rt_bin_out);
    end
  endtask

  task automatic test_encode_sweep();
    for (int i = 0; i < N; i++) begin
      drive(1'b1, W'(i), model_oh(i), W'(i), 1'b0);
      e = pop_exp();
      n_cmp++; if (oh_out !== e.oh || out_valid !== 1'b1) begin
        n_bad++; $display("FAIL enc_oh[%0d] got ov=%b oh=%h want ov=1 oh=%h", i, out_valid, oh_out, e.oh);
      end
      n_cmp++; if (rt_bin_out !== e.rt) begin
        n_bad++; $display("FAIL enc_rt[%0d] got %0d want %0d", i, rt_bin_out, e.rt);
      end
      n_cmp++; if (bin_out !== e.bin || oh_err !== e.err) begin
        n_bad++; $display("FAIL enc_dec[%0d] got bin=%0d err=%b want bin=%0d err=%b",
                          i, bin_out, oh_err, e.bin, e.err);
      end
    end
  endtask

  task automatic test_decode();
    logic [N-1:0] vec [6] = '{16'h8000, 16'h0001, 16'h0000, 16'h0003, 16'h0030, 16'h0240};
    logic [W-1:0] eb  [6] = '{4'd15, 4'd0, 4'd0, 4'd1, 4'd5, 4'd15};
    logic         ee  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [W-1:0] b;
    for (int i = 0; i < 6; i++) begin
      b = W'($urandom_range(0, N-1));
      drive(1'b1, b, vec[i], eb[i], ee[i]);
      e = pop_exp();
      n_cmp++; if (bin_out !== e.bin) begin
        n_bad++; $display("FAIL dec_bin[%h] got %0d want %0d", vec[i], bin_out, e.bin);
      end
      n_cmp++; if (oh_err !== e.err) begin
        n_bad++; $display("FAIL dec_err[%h] got %b want %b", vec[i], oh_err, e.err);
      end
      n_cmp++; if (oh_out !== e.oh || rt_bin_out !== e.rt) begin
        n_bad++; $display("FAIL dec_indep[%h] got oh=%h rt=%0d want oh=%h rt=%0d",
                          vec[i], oh_out, rt_bin_out, e.oh, e.rt);
      end
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 4'd9, 16'h0003, 4'd1, 1'b1);
    e = pop_exp();
    n_cmp++; if (oh_out !== 16'h0200 || out_valid !== 1'b1) begin
      n_bad++; $display("FAIL hold_load got ov=%b oh=%h want ov=1 oh=0200", out_valid, oh_out);
    end
    drive(1'b0, 4'd2, 16'h0010, 4'd4, 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL hold_ov got %b want 0", out_valid);
    end
    n_cmp++; if (oh_out !== 16'h0200 || rt_bin_out !== 4'd9) begin
      n_bad++; $display("FAIL hold_oh got oh=%h rt=%0d want oh=0200 rt=9", oh_out, rt_bin_out);
    end
    n_cmp++; if (bin_out !== 4'd1 || oh_err !== ERR_EN) begin
      n_bad++; $display("FAIL hold_dec got bin=%0d err=%b want bin=1 err=%b", bin_out, oh_err, ERR_EN);
    end
    n_cmp++; if (sb.size() != 0) begin
      n_bad++; $display("FAIL hold_sb got %0d pending want 0", sb.size());
    end
  endtask

  task automatic test_loopback();
    logic [W-1:0] prev;
    prev = 4'd9;
    for (int j = 0; j <= N; j++) begin
      drive(1'b1, W'(j % N), oh_out, prev, 1'b0);
      prev = W'(j % N);
      e = pop_exp();
      n_cmp++; if (bin_out !== e.bin || oh_err !== 1'b0) begin
        n_bad++; $display("FAIL loop_bin[%0d] got bin=%0d err=%b want bin=%0d err=0", j, bin_out, oh_err, e.bin);
      end
      n_cmp++; if (oh_out !== e.oh) begin
        n_bad++; $display("FAIL loop_oh[%0d] got %h want %h", j, oh_out, e.oh);
      end
    end
  endtask

  initial begin
    test_reset();
    test_encode_sweep();
    test_decode();
    test_hold();
    test_loopback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
